// File: rtl/parser_act_ram_ctrl.sv
// Parse-action RAM controller: arbitrates datapath lookups against control-path
// table writes onto a single-port RAM and tracks which entries have been written.
module parser_act_ram_ctrl #(
  parameter int unsigned C_VLANID_WIDTH = 12,
  parameter int unsigned C_ADDR_WIDTH   = 5,
  parameter int unsigned C_ACT_WIDTH    = 160
) (
  input  logic                      axis_clk,
  input  logic                      aresetn,
  input  logic                      lkup_req_valid,
  input  logic [C_VLANID_WIDTH-1:0] lkup_req_vlan,
  output logic                      lkup_req_ready,
  output logic                      lkup_rsp_valid,
  output logic [C_ACT_WIDTH-1:0]    lkup_rsp_act,
  output logic                      lkup_rsp_miss,
  input  logic                      lkup_rsp_ready,
  input  logic                      cfg_wr_valid,
  input  logic [C_ADDR_WIDTH-1:0]   cfg_wr_addr,
  input  logic [C_ACT_WIDTH-1:0]    cfg_wr_data,
  output logic                      cfg_wr_ready,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [C_ADDR_WIDTH-1:0]   ram_addr,
  output logic [C_ACT_WIDTH-1:0]    ram_din,
  input  logic [C_ACT_WIDTH-1:0]    ram_dout,
  output logic [15:0]               cfg_wr_cnt
);

  localparam int unsigned DEPTH   = 1 << C_ADDR_WIDTH;
  localparam int unsigned CNT_W   = 16;
  localparam logic        GNT_CFG = 1'b0;
  localparam logic        GNT_LKP = 1'b1;

  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_DATA, RSP} state_t;

  state_t                  state, state_d;
  logic                    last_grant, last_grant_d;
  logic [DEPTH-1:0]        valid_map, valid_map_d;
  logic [C_ADDR_WIDTH-1:0] rd_addr, rd_addr_d;
  logic                    ram_en_d, ram_we_d;
  logic [C_ADDR_WIDTH-1:0] ram_addr_d;
  logic [C_ACT_WIDTH-1:0]  ram_din_d;
  logic                    rsp_valid_d, rsp_miss_d;
  logic [C_ACT_WIDTH-1:0]  rsp_act_d;
  logic [CNT_W-1:0]        cnt_d;

  // Key bits above the RAM address select nothing; fold them away explicitly.
  generate
    if (C_VLANID_WIDTH > C_ADDR_WIDTH) begin : g_key_hi
      logic unused_key_hi;
      assign unused_key_hi = ^lkup_req_vlan[C_VLANID_WIDTH-1:C_ADDR_WIDTH];
    end
  endgenerate

  // State register and all registered outputs.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state          <= IDLE;
      last_grant     <= GNT_CFG;
      valid_map      <= '0;
      rd_addr        <= '0;
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= '0;
      lkup_rsp_valid <= 1'b0;
      lkup_rsp_act   <= '0;
      lkup_rsp_miss  <= 1'b0;
      cfg_wr_cnt     <= '0;
    end else begin
      state          <= state_d;
      last_grant     <= last_grant_d;
      valid_map      <= valid_map_d;
      rd_addr        <= rd_addr_d;
      ram_en         <= ram_en_d;
      ram_we         <= ram_we_d;
      ram_addr       <= ram_addr_d;
      ram_din        <= ram_din_d;
      lkup_rsp_valid <= rsp_valid_d;
      lkup_rsp_act   <= rsp_act_d;
      lkup_rsp_miss  <= rsp_miss_d;
      cfg_wr_cnt     <= cnt_d;
    end
  end

  // Arbitration, next state and next output values.
  always_comb begin
    state_d        = state;
    last_grant_d   = last_grant;
    valid_map_d    = valid_map;
    rd_addr_d      = rd_addr;
    ram_en_d       = 1'b0;
    ram_we_d       = 1'b0;
    ram_addr_d     = ram_addr;
    ram_din_d      = ram_din;
    rsp_valid_d    = lkup_rsp_valid;
    rsp_act_d      = lkup_rsp_act;
    rsp_miss_d     = lkup_rsp_miss;
    cnt_d          = cfg_wr_cnt;
    lkup_req_ready = 1'b0;
    cfg_wr_ready   = 1'b0;

    unique case (state)
      IDLE: begin
        // On conflict the side not granted last wins.
        lkup_req_ready = lkup_req_valid && (!cfg_wr_valid || (last_grant == GNT_CFG));
        cfg_wr_ready   = cfg_wr_valid && (!lkup_req_valid || (last_grant == GNT_LKP));
        if (lkup_req_ready) begin
          state_d      = RD_WAIT;
          last_grant_d = GNT_LKP;
          ram_en_d     = 1'b1;
          ram_addr_d   = lkup_req_vlan[C_ADDR_WIDTH-1:0];
          rd_addr_d    = lkup_req_vlan[C_ADDR_WIDTH-1:0];
        end else if (cfg_wr_ready) begin
          state_d                  = WR;
          last_grant_d             = GNT_CFG;
          ram_en_d                 = 1'b1;
          ram_we_d                 = 1'b1;
          ram_addr_d               = cfg_wr_addr;
          ram_din_d                = cfg_wr_data;
          valid_map_d[cfg_wr_addr] = 1'b1;
          if (cfg_wr_cnt != {CNT_W{1'b1}}) begin
            cnt_d = cfg_wr_cnt + CNT_W'(1);
          end
        end
      end
      WR:      state_d = IDLE;
      RD_WAIT: state_d = RD_DATA;
      RD_DATA: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_miss_d  = !valid_map[rd_addr];
        rsp_act_d   = valid_map[rd_addr] ? ram_dout : '0;
      end
      RSP: begin
        if (lkup_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parser_act_ram_ctrl.sv
// Directed self-checking bench for parser_act_ram_ctrl with a behavioural
// single-port RAM attached to its RAM port.
module tb_parser_act_ram_ctrl;

  logic         axis_clk;
  logic         aresetn;
  logic         lkup_req_valid;
  logic [11:0]  lkup_req_vlan;
  logic         lkup_req_ready;
  logic         lkup_rsp_valid;
  logic [159:0] lkup_rsp_act;
  logic         lkup_rsp_miss;
  logic         lkup_rsp_ready;
  logic         cfg_wr_valid;
  logic [4:0]   cfg_wr_addr;
  logic [159:0] cfg_wr_data;
  logic         cfg_wr_ready;
  logic         ram_en;
  logic         ram_we;
  logic [4:0]   ram_addr;
  logic [159:0] ram_din;
  logic [159:0] ram_dout;
  logic [15:0]  cfg_wr_cnt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [159:0] PAT_A5 = {20{8'hA5}};
  localparam logic [159:0] PAT_3C = {20{8'h3C}};
  localparam logic [159:0] PAT_C3 = {20{8'hC3}};
  localparam logic [159:0] JUNK   = {5{32'hDEAD_BEEF}};

  parser_act_ram_ctrl dut (
    .axis_clk       (axis_clk),
    .aresetn        (aresetn),
    .lkup_req_valid (lkup_req_valid),
    .lkup_req_vlan  (lkup_req_vlan),
    .lkup_req_ready (lkup_req_ready),
    .lkup_rsp_valid (lkup_rsp_valid),
    .lkup_rsp_act   (lkup_rsp_act),
    .lkup_rsp_miss  (lkup_rsp_miss),
    .lkup_rsp_ready (lkup_rsp_ready),
    .cfg_wr_valid   (cfg_wr_valid),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_data    (cfg_wr_data),
    .cfg_wr_ready   (cfg_wr_ready),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .cfg_wr_cnt     (cfg_wr_cnt)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // Unwritten RAM words read back as junk so a miss must really zero the result.
  logic [159:0] mem [32];
  logic [31:0]  mem_written = '0;
  always @(posedge axis_clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]         <= ram_din;
        mem_written[ram_addr] <= 1'b1;
      end else begin
        ram_dout <= mem_written[ram_addr] ? mem[ram_addr] : JUNK;
      end
    end
  end

  task automatic apply_reset();
    @(negedge axis_clk);
    aresetn = 1'b0; lkup_req_valid = 1'b0; cfg_wr_valid = 1'b0; lkup_rsp_ready = 1'b0;
    repeat (2) @(negedge axis_clk);
    aresetn = 1'b1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [159:0] data,
                          input logic [15:0] exp_cnt, input string tag);
    @(negedge axis_clk);
    cfg_wr_valid = 1'b1; cfg_wr_addr = addr; cfg_wr_data = data;
    #1;
    n_cmp++;
    if (cfg_wr_ready !== 1'b1) begin
      n_err++; $display("FAIL %s wr_ready: got %b want 1", tag, cfg_wr_ready);
    end
    @(negedge axis_clk);
    cfg_wr_valid = 1'b0;
    n_cmp++;
    if ({ram_en, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, addr, data}) begin
      n_err++; $display("FAIL %s wr_ram: got en=%b we=%b addr=%0d din=%h want 1 1 %0d %h",
                        tag, ram_en, ram_we, ram_addr, ram_din, addr, data);
    end
    n_cmp++;
    if (cfg_wr_cnt !== exp_cnt) begin
      n_err++; $display("FAIL %s wr_cnt: got %h want %h", tag, cfg_wr_cnt, exp_cnt);
    end
    @(negedge axis_clk);
    n_cmp++;
    if ({ram_en, ram_we} !== 2'b00) begin
      n_err++; $display("FAIL %s wr_done: got en=%b we=%b want 0 0", tag, ram_en, ram_we);
    end
  endtask

  task automatic do_lookup(input logic [11:0] vlan, input logic [4:0] exp_addr,
                           input logic [159:0] exp_act, input logic exp_miss,
                           input int hold, input string tag);
    @(negedge axis_clk);
    lkup_req_valid = 1'b1; lkup_req_vlan = vlan; lkup_rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (lkup_req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s req_ready: got %b want 1", tag, lkup_req_ready);
    end
    @(negedge axis_clk);
    lkup_req_valid = 1'b0;
    n_cmp++;
    if ({ram_en, ram_we, ram_addr, lkup_rsp_valid} !== {1'b1, 1'b0, exp_addr, 1'b0}) begin
      n_err++; $display("FAIL %s rd_issue: got en=%b we=%b addr=%0d rv=%b want 1 0 %0d 0",
                        tag, ram_en, ram_we, ram_addr, lkup_rsp_valid, exp_addr);
    end
    @(negedge axis_clk);
    n_cmp++;
    if ({ram_en, lkup_rsp_valid} !== 2'b00) begin
      n_err++; $display("FAIL %s rd_wait: got en=%b rv=%b want 0 0", tag, ram_en, lkup_rsp_valid);
    end
    @(negedge axis_clk);
    n_cmp++;
    if ({lkup_rsp_valid, lkup_rsp_miss, lkup_rsp_act} !== {1'b1, exp_miss, exp_act}) begin
      n_err++; $display("FAIL %s rsp: got v=%b miss=%b act=%h want 1 %b %h",
                        tag, lkup_rsp_valid, lkup_rsp_miss, lkup_rsp_act, exp_miss, exp_act);
    end
    for (int i = 0; i < hold; i++) begin
      lkup_req_valid = 1'b1; cfg_wr_valid = 1'b1;
      #1;
      n_cmp++;
      if ({lkup_req_ready, cfg_wr_ready} !== 2'b00) begin
        n_err++; $display("FAIL %s hold_ready[%0d]: got %b%b want 00", tag, i,
                          lkup_req_ready, cfg_wr_ready);
      end
      @(negedge axis_clk);
      n_cmp++;
      if ({lkup_rsp_valid, lkup_rsp_miss, lkup_rsp_act, ram_en} !== {1'b1, exp_miss, exp_act, 1'b0}) begin
        n_err++; $display("FAIL %s hold[%0d]: got v=%b miss=%b act=%h en=%b want 1 %b %h 0",
                          tag, i, lkup_rsp_valid, lkup_rsp_miss, lkup_rsp_act, ram_en, exp_miss, exp_act);
      end
    end
    lkup_req_valid = 1'b0; cfg_wr_valid = 1'b0; lkup_rsp_ready = 1'b1;
    @(negedge axis_clk);
    lkup_rsp_ready = 1'b0;
    n_cmp++;
    if (lkup_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL %s rsp_release: got v=%b want 0", tag, lkup_rsp_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge axis_clk);
    aresetn = 1'b0; lkup_req_valid = 1'b0; cfg_wr_valid = 1'b0; lkup_rsp_ready = 1'b0;
    lkup_req_vlan = '0; cfg_wr_addr = '0; cfg_wr_data = '0;
    repeat (2) @(negedge axis_clk);
    n_cmp++;
    if ({lkup_req_ready, lkup_rsp_valid, lkup_rsp_miss, cfg_wr_ready, ram_en, ram_we} !== 6'b0 ||
        ram_addr !== 5'd0 || ram_din !== 160'd0 || lkup_rsp_act !== 160'd0 || cfg_wr_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_outputs: got rr=%b rv=%b m=%b wr=%b en=%b we=%b addr=%0d cnt=%h want all 0",
                        lkup_req_ready, lkup_rsp_valid, lkup_rsp_miss, cfg_wr_ready, ram_en, ram_we,
                        ram_addr, cfg_wr_cnt);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_write_read();
    do_write(5'd3, PAT_A5, 16'd1, "wr_a5");
    do_lookup(12'h003, 5'd3, PAT_A5, 1'b0, 0, "rd_a5");
  endtask

  task automatic test_overwrite_hold();
    do_write(5'd3, PAT_3C, 16'd2, "overwrite");
    do_lookup(12'hFE3, 5'd3, PAT_3C, 1'b0, 5, "rd_hold");
  endtask

  task automatic test_miss();
    apply_reset();
    do_lookup(12'h007, 5'd7, 160'd0, 1'b1, 0, "miss7");
  endtask

  task automatic test_reset_mid();
    do_write(5'd5, PAT_C3, 16'd1, "wr5");
    @(negedge axis_clk);
    lkup_req_valid = 1'b1; lkup_req_vlan = 12'h005;
    @(negedge axis_clk);
    lkup_req_valid = 1'b0;
    @(negedge axis_clk);
    aresetn = 1'b0;
    @(negedge axis_clk);
    n_cmp++;
    if ({lkup_rsp_valid, ram_en, cfg_wr_cnt} !== {1'b0, 1'b0, 16'd0}) begin
      n_err++; $display("FAIL reset_mid: got rv=%b en=%b cnt=%h want 0 0 0",
                        lkup_rsp_valid, ram_en, cfg_wr_cnt);
    end
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_clk);
      n_cmp++;
      if (lkup_rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_mid_quiet[%0d]: got rv=%b want 0", i, lkup_rsp_valid);
      end
    end
    do_lookup(12'h005, 5'd5, 160'd0, 1'b1, 0, "miss5_after_reset");
  endtask

  task automatic test_arbitration();
    logic exp_l;
    logic [5:0] seq;
    int got;
    int cycles;
    seq = '0; got = 0; cycles = 0;
    @(negedge axis_clk);
    aresetn = 1'b0; lkup_req_valid = 1'b1; cfg_wr_valid = 1'b1; lkup_rsp_ready = 1'b1;
    lkup_req_vlan = 12'h009; cfg_wr_addr = 5'd9; cfg_wr_data = PAT_A5;
    repeat (2) @(negedge axis_clk);
    aresetn = 1'b1;
    while (got < 6 && cycles < 200) begin
      #1;
      if (lkup_req_ready && cfg_wr_ready) begin
        n_cmp++; n_err++; $display("FAIL arb_both_ready: got 11 want one-hot");
      end
      if (lkup_req_ready) begin seq[got] = 1'b1; got++; end
      else if (cfg_wr_ready) begin seq[got] = 1'b0; got++; end
      @(negedge axis_clk);
      cycles++;
    end
    lkup_req_valid = 1'b0; cfg_wr_valid = 1'b0;
    n_cmp++;
    if (got != 6) begin
      n_err++; $display("FAIL arb_timeout: got %0d grants want 6", got);
    end
    for (int i = 0; i < 6; i++) begin
      exp_l = (i % 2 == 0);
      n_cmp++;
      if (seq[i] !== exp_l) begin
        n_err++; $display("FAIL arb_grant[%0d]: got lookup=%b want %b", i, seq[i], exp_l);
      end
    end
    repeat (4) @(negedge axis_clk);
    lkup_rsp_ready = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    @(negedge axis_clk);
    force dut.cfg_wr_cnt = 16'hFFFE;
    @(negedge axis_clk);
    release dut.cfg_wr_cnt;
    #1;
    n_cmp++;
    if (cfg_wr_cnt !== 16'hFFFE) begin
      n_err++; $display("FAIL sat_preload: got %h want fffe", cfg_wr_cnt);
    end
    do_write(5'd1, PAT_3C, 16'hFFFF, "sat_to_max");
    do_write(5'd2, PAT_C3, 16'hFFFF, "sat_hold");
  endtask

  initial begin
    aresetn = 1'b0; lkup_req_valid = 1'b0; cfg_wr_valid = 1'b0; lkup_rsp_ready = 1'b0;
    lkup_req_vlan = '0; cfg_wr_addr = '0; cfg_wr_data = '0;
    test_reset();
    test_write_read();
    test_overwrite_hold();
    test_miss();
    test_reset_mid();
    test_arbitration();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parser_act_ram_ctrl.md
PARSER_ACT_RAM_CTRL -- requirements
Module: parser_act_ram_ctrl

Interface
REQ-001 The block SHALL have parameter C_VLANID_WIDTH, default 12, giving the lookup key width.
REQ-002 The block SHALL have parameter C_ADDR_WIDTH, default 5, giving the parse-action RAM address width (32 entries).
REQ-003 The block SHALL have parameter C_ACT_WIDTH, default 160, giving the parse-action entry width.
REQ-004 The block SHALL have one clock and a synchronous active-low reset; ports are listed in REQ-005 to REQ-023.
REQ-005 axis_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 aresetn  in  1  synchronous, active-low reset.
REQ-007 lkup_req_valid  in  1  datapath lookup request.
REQ-008 lkup_req_vlan  in  C_VLANID_WIDTH  lookup key.
REQ-009 lkup_req_ready  out  1  lookup accepted when high with lkup_req_valid.
REQ-010 lkup_rsp_valid  out  1  lookup result available.
REQ-011 lkup_rsp_act  out  C_ACT_WIDTH  parse-action entry read.
REQ-012 lkup_rsp_miss  out  1  entry never written since reset.
REQ-013 lkup_rsp_ready  in  1  consumer takes the result.
REQ-014 cfg_wr_valid  in  1  control-path table write request.
REQ-015 cfg_wr_addr  in  C_ADDR_WIDTH  entry index to write.
REQ-016 cfg_wr_data  in  C_ACT_WIDTH  entry contents.
REQ-017 cfg_wr_ready  out  1  write accepted when high with cfg_wr_valid.
REQ-018 ram_en  out  1  RAM port enable, registered.
REQ-019 ram_we  out  1  RAM write enable, registered.
REQ-020 ram_addr  out  C_ADDR_WIDTH  RAM address, registered.
REQ-021 ram_din  out  C_ACT_WIDTH  RAM write data, registered.
REQ-022 ram_dout  in  C_ACT_WIDTH  RAM read data, valid one cycle after the cycle ram_en is high.
REQ-023 cfg_wr_cnt  out  16  count of accepted writes.

Function
REQ-024 The FSM SHALL have states IDLE, WR, RD_WAIT, RD_DATA, RSP.
REQ-025 lkup_req_ready and cfg_wr_ready SHALL be combinational from state, both valids and last_grant only, never from either ready, and SHALL be low outside IDLE.
REQ-026 In IDLE with exactly one valid, that requester SHALL be granted.
REQ-027 In IDLE with both valids, the requester not granted last SHALL be granted; last_grant resets to cfg, so lookup wins the first conflict.
REQ-028 Write accept at edge E: ram_en=ram_we=1, ram_addr=cfg_wr_addr, ram_din=cfg_wr_data during cycle E..E+1; state WR; valid bit [cfg_wr_addr] set; cfg_wr_cnt incremented.
REQ-029 WR SHALL return to IDLE at E+1 with ram_en=ram_we=0.
REQ-030 cfg_wr_cnt SHALL saturate at 16'hFFFF.
REQ-031 Lookup accept at edge E: ram_en=1, ram_we=0, ram_addr=lkup_req_vlan[C_ADDR_WIDTH-1:0]; key captured; state RD_WAIT.
REQ-032 At E+1, state SHALL be RD_DATA with ram_en=0.
REQ-033 At E+2, lkup_rsp_act SHALL be ram_dout; lkup_rsp_miss SHALL be the inverted valid bit of the captured address, with lkup_rsp_act forced to zero when missed; lkup_rsp_valid=1; state RSP.
REQ-034 In RSP, lkup_rsp_valid, lkup_rsp_act and lkup_rsp_miss SHALL hold stable until lkup_rsp_ready=1; the block returns to IDLE on that edge with lkup_rsp_valid=0.
REQ-035 At most one lookup SHALL be outstanding; a write issued in the same IDLE cycle as a lookup is impossible by REQ-025/027.
REQ-036 A write to an address already valid SHALL overwrite the entry and keep its valid bit set.

Reset
REQ-037 While aresetn=0 at a rising edge: state IDLE, all outputs 0, valid bitmap cleared, last_grant=cfg, cfg_wr_cnt=0.
REQ-038 Reset mid-operation SHALL discard any pending lookup or response without asserting lkup_rsp_valid.

Verification
REQ-039 Write addr 3, data 160'hA5..A5 -> ram_we high exactly one cycle, cfg_wr_cnt=1; then lookup vlan 12'h003 -> lkup_rsp_valid at E+2, act=A5..A5, miss=0.
REQ-040 Lookup vlan 12'h007 after reset, no writes -> act=0, miss=1.
REQ-041 Both valid continuously from reset -> grants alternate lookup, write, lookup, write, ...
REQ-042 Hold lkup_rsp_ready=0 for 5 cycles in RSP -> response stable, both readies low, no RAM access.
REQ-043 Reset asserted in RD_DATA -> next cycle IDLE, lkup_rsp_valid stays 0, miss for previously written address.
REQ-044 Force cfg_wr_cnt to 16'hFFFF, one more write -> stays 16'hFFFF.
